// File: rtl/count_uart_pkg.sv
// Shared definitions for the counter-value UART transmitter.
//   uart_state_e         : transmitter FSM states
//   CLKS_PER_BIT_DEFAULT : default clock cycles per serial bit
//   BITS_PER_FRAME       : start + 8 data + stop
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned BITS_PER_FRAME       = 10;

endpackage

// File: rtl/count_uart_baud.sv
// Bit-period timer for count_uart_tx.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   restart : hold the counter at zero (parent drives this while idle)
//   tick    : high in the last cycle of a bit period (count == CLKS_PER_BIT-1)
module count_uart_baud #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCnt);

  // Wrapping on tick means every state entry (all happen on a tick or from
  // idle, where restart holds zero) starts the new bit at count 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 serial transmitter for the counter value.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   data_in    : byte to send, captured on the handshake edge
//   in_valid   : upstream byte valid
//   in_ready   : block idle and able to accept a byte
//   tx         : registered serial line, idles high, LSB first
//   busy       : frame in progress (!in_ready)
//   frame_done : one-cycle pulse in the last stop-bit cycle
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gen_bad_divider
    $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        tick;
  logic        accept;
  logic        baud_restart;

  assign accept       = in_valid && (state_q == IDLE);
  assign baud_restart = (state_q == IDLE);

  count_uart_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && (idx_q == 3'd7)) state_d = STOP;
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register and bit index
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (accept) begin
      shift_d = data_in;
      idx_d   = 3'd0;
    end else if ((state_q == DATA) && tick && (idx_q != 3'd7)) begin
      shift_d = {1'b0, shift_q[7:1]};
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Outputs. tx is computed from the next state so the registered line is
  // aligned with the state it belongs to (no input-to-pin combinational path).
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:  tx_d = 1'b1;
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_d[0];
      STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    frame_done = (state_q == STOP) && tick;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_count_uart_tx.sv
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in, data_in2;
  logic       in_valid, in_valid2;
  logic       in_ready, tx, busy, frame_done;
  logic       in_ready2, tx2, busy2, frame_done2;

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0, done_seen2 = 0;
  int done_exp = 0, done_exp2 = 0;

  logic [7:0] b, nb;
  bit         ch;
  bit         sel;

  always #5 clk = ~clk;

  count_uart_tx #(
    .CLKS_PER_BIT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  count_uart_tx #(
    .CLKS_PER_BIT (2)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in2),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .frame_done (frame_done2)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (frame_done2 === 1'b1) done_seen2++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input bit s, input logic v, input logic [7:0] d);
    if (s) begin
      in_valid2 = v;
      data_in2  = d;
    end else begin
      in_valid = v;
      data_in  = d;
    end
  endtask

  task automatic check_idle(input bit s);
    check_eq("idle_tx",    s ? tx2 : tx, 1);
    check_eq("idle_ready", s ? in_ready2 : in_ready, 1);
    check_eq("idle_busy",  s ? busy2 : busy, 0);
    check_eq("idle_done",  s ? frame_done2 : frame_done, 0);
  endtask

  // Caller has driven in_valid=1 with byte b at a negedge while idle. The model
  // is the frame as a 10-slot bit vector, each slot held for c cycles. During
  // the frame random (ignored) traffic is driven; on the last cycle the next
  // byte is offered if chaining.
  task automatic run_frame(input bit s, input logic [7:0] fb, input bit chain,
                           input logic [7:0] nxt, input bit fixed_junk,
                           input logic [7:0] junk);
    int         c;
    logic [9:0] frame;
    c     = s ? 2 : 4;
    frame = {1'b1, fb, 1'b0};
    @(posedge clk);
    #1;
    for (int k = 0; k < 10 * c; k++) begin
      @(negedge clk);
      check_eq("tx_bit",   s ? tx2 : tx, frame[k / c]);
      check_eq("done",     s ? frame_done2 : frame_done, (k == 10 * c - 1) ? 1 : 0);
      check_eq("ready_lo", s ? in_ready2 : in_ready, 0);
      check_eq("busy_hi",  s ? busy2 : busy, 1);
      if (k == 10 * c - 1) drive(s, chain, nxt);
      else drive(s, 1'($urandom_range(0, 1)), fixed_junk ? junk : 8'($urandom));
    end
    if (s) done_exp2++;
    else done_exp++;
    @(negedge clk);
    check_idle(s);
  endtask

  initial begin
    // Reset with arbitrary inputs
    rst_n = 1'b0;
    drive(0, 1'b1, 8'($urandom));
    drive(1, 1'b1, 8'($urandom));
    repeat (3) begin
      @(negedge clk);
      check_idle(0);
      check_idle(1);
    end
    drive(0, 1'b0, 8'($urandom));
    drive(1, 1'b0, 8'($urandom));
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle(0);
      check_idle(1);
    end

    // Single frame
    drive(0, 1'b1, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);

    // Back-to-back with in_valid held
    drive(0, 1'b1, 8'h00);
    run_frame(0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00);
    run_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);

    // Ignored mid-frame traffic
    drive(0, 1'b1, 8'h81);
    run_frame(0, 8'h81, 1'b0, 8'h00, 1'b1, 8'h3C);
    @(negedge clk);
    check_idle(0);

    // Reset during data bit 3 (bit 3 of 0xF7 is 0, so tx must rise)
    drive(0, 1'b1, 8'hF7);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'($urandom));
    repeat (18) @(negedge clk);
    check_eq("pre_rst_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_tx", tx, 1);
    check_eq("rst_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check_idle(0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0);
    drive(0, 1'b1, 8'h5A);
    run_frame(0, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00);

    // Minimum divider
    drive(1, 1'b1, 8'h01);
    run_frame(1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);

    // Random bytes, random chaining, both dividers
    b = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      sel = (i % 2) == 1;
      nb  = 8'($urandom);
      ch  = 1'($urandom_range(0, 1));
      drive(sel, 1'b1, b);
      run_frame(sel, b, ch, nb, 1'b0, 8'h00);
      if (ch) run_frame(sel, nb, 1'b0, 8'h00, 1'b0, 8'h00);
      b = 8'($urandom);
    end

    @(negedge clk);
    check_eq("done_count",  done_seen,  done_exp);
    check_eq("done_count2", done_seen2, done_exp2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
